// File: rtl/gearbox_pack.sv
// gearbox_pack: narrow-to-wide packing gearbox; the first accepted word of each wide word lands in the top-most lane.
// Define GEARBOX_PACK_SKID_EN to place an output register behind the accumulator for full-rate operation.
module gearbox_pack #(
    parameter int  INPUT_DATA_W  = 16,
    parameter int  OUTPUT_DATA_W = 64,
    localparam int NUM_LANES     = OUTPUT_DATA_W / INPUT_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [INPUT_DATA_W-1:0]  data_i,
    input  logic                     valid_i,
    input  logic                     last_i,
    output logic                     ready_o,
    output logic [OUTPUT_DATA_W-1:0] data_o,
    output logic [NUM_LANES-1:0]     keep_o,
    output logic                     last_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    localparam int CNT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);

    if (NUM_LANES < 2 || NUM_LANES * INPUT_DATA_W != OUTPUT_DATA_W) begin : g_bad_cfg
        $error("gearbox_pack: OUTPUT_DATA_W must be an integer multiple (>=2) of INPUT_DATA_W");
    end

    typedef enum logic {FILL, FULL} state_t;

    state_t                   state;
    state_t                   next_state;
    logic                     running;
    logic [CNT_W-1:0]         count;
    logic [OUTPUT_DATA_W-1:0] acc_data;
    logic [NUM_LANES-1:0]     acc_keep;
    logic [OUTPUT_DATA_W-1:0] merged_data;
    logic [NUM_LANES-1:0]     merged_keep;
    logic [OUTPUT_DATA_W-1:0] load_data;
    logic [NUM_LANES-1:0]     load_keep;
    logic                     load_last;
    logic                     accept;
    logic                     complete;
    logic                     acc_clear;
    logic                     load_out;

    // Holds ready_o low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        merged_data = acc_data;
        merged_keep = acc_keep;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (count == CNT_W'(k)) begin
                merged_data[OUTPUT_DATA_W-1-k*INPUT_DATA_W -: INPUT_DATA_W] = data_i;
                merged_keep[NUM_LANES-1-k] = 1'b1;
            end
        end
    end

`ifdef GEARBOX_PACK_SKID_EN
    logic acc_last;
    logic space;

    // FULL here means the accumulator holds a complete word waiting for the output register.
    always_comb begin
        next_state = state;
        ready_o    = 1'b0;
        accept     = 1'b0;
        complete   = 1'b0;
        acc_clear  = 1'b0;
        load_out   = 1'b0;
        load_data  = merged_data;
        load_keep  = merged_keep;
        load_last  = last_i;
        space      = ~valid_o | ready_i;
        unique case (state)
            FILL: begin
                ready_o  = running;
                accept   = valid_i & running;
                complete = accept & ((count == LAST_LANE) | last_i);
                if (complete) begin
                    if (space) begin
                        load_out  = 1'b1;
                        acc_clear = 1'b1;
                    end else begin
                        next_state = FULL;
                    end
                end
            end
            FULL: begin
                if (space) begin
                    load_out   = 1'b1;
                    acc_clear  = 1'b1;
                    load_data  = acc_data;
                    load_keep  = acc_keep;
                    load_last  = acc_last;
                    next_state = FILL;
                end
            end
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_last <= 1'b0;
        end else if (acc_clear) begin
            acc_last <= 1'b0;
        end else if (accept) begin
            acc_last <= last_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
        end else if (load_out) begin
            valid_o <= 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end
`else
    always_comb begin
        next_state = state;
        ready_o    = 1'b0;
        accept     = 1'b0;
        complete   = 1'b0;
        acc_clear  = 1'b0;
        load_out   = 1'b0;
        load_data  = merged_data;
        load_keep  = merged_keep;
        load_last  = last_i;
        unique case (state)
            FILL: begin
                ready_o  = running;
                accept   = valid_i & running;
                complete = accept & ((count == LAST_LANE) | last_i);
                if (complete) begin
                    load_out   = 1'b1;
                    acc_clear  = 1'b1;
                    next_state = FULL;
                end
            end
            FULL: begin
                if (ready_i) begin
                    next_state = FILL;
                end
            end
            default: next_state = FILL;
        endcase
    end

    assign valid_o = (state == FULL);
`endif

    // The completing word goes straight to the output registers, so the accumulator
    // is already empty when the next burst starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data <= '0;
            acc_keep <= '0;
            count    <= '0;
        end else if (acc_clear) begin
            acc_data <= '0;
            acc_keep <= '0;
            count    <= '0;
        end else if (accept) begin
            acc_data <= merged_data;
            acc_keep <= merged_keep;
            count    <= complete ? '0 : count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o <= '0;
            keep_o <= '0;
            last_o <= 1'b0;
        end else if (load_out) begin
            data_o <= load_data;
            keep_o <= load_keep;
            last_o <= load_last;
        end
    end

endmodule
